// File: rtl/dcache_nway.sv
// dcache_nway: write-back, write-allocate, set-associative data cache with
// true-LRU replacement and a halt-time flush that also stores the hit count.
// Ports:
//   CLK, RST              clock and synchronous active-high reset
//   dmemREN/dmemWEN       datapath read/write request (write wins)
//   dmemaddr/dmemstore    datapath byte address and write data
//   halt                  start flush, held until reset
//   dhit/dmemload         request serviced this cycle / read data
//   flushed               flush complete, sticky until reset
//   dREN/dWEN/daddr/dstore memory-side request, byte address, write data
//   dwait/dload           memory busy / memory read data
module dcache_nway #(
  parameter int unsigned SETS     = 8,
  parameter int unsigned WAYS     = 2,
  parameter int unsigned WPB      = 2,
  parameter logic [31:0] CNT_ADDR = 32'h3100
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic [31:0] dload
);

  localparam int unsigned WBITS = $clog2(WPB);
  localparam int unsigned IBITS = $clog2(SETS);
  localparam int unsigned TBITS = 30 - WBITS - IBITS;
  localparam int unsigned WW    = (WBITS == 0) ? 1 : WBITS;
  localparam int unsigned AW    = (WAYS == 1) ? 1 : $clog2(WAYS);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WB    = 3'd1;
  localparam logic [2:0] S_ALLOC = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_CNT   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [31:0]      data_q  [SETS][WAYS][WPB];
  logic [TBITS-1:0] tag_q   [SETS][WAYS];
  logic             valid_q [SETS][WAYS];
  logic             dirty_q [SETS][WAYS];
  logic [AW-1:0]    age_q   [SETS][WAYS];

  logic [2:0]       state_q, state_d;
  logic [AW-1:0]    vic_q;
  logic [TBITS-1:0] mtag_q;
  logic [IBITS-1:0] midx_q;
  logic [WW-1:0]    wcnt_q;
  logic             missed_q;
  logic [31:0]      hitcnt_q;
  logic [IBITS-1:0] fset_q;
  logic [AW-1:0]    fway_q;

  logic             req;
  logic [IBITS-1:0] ridx;
  logic [TBITS-1:0] rtag;
  logic [WW-1:0]    rword;
  logic             hit;
  logic [AW-1:0]    hit_way;
  logic [AW-1:0]    vic;
  logic             wb_last;
  logic             fl_dirty;
  logic             fl_last;
  logic             unused_addr_bits;

  // Rebuild a byte address from block coordinates.
  function automatic logic [31:0] mk_addr(input logic [TBITS-1:0] t,
                                          input logic [IBITS-1:0] i,
                                          input logic [WW-1:0]    w);
    return (32'(t) << (2 + WBITS + IBITS)) | (32'(i) << (2 + WBITS)) | (32'(w) << 2);
  endfunction

  assign unused_addr_bits = ^dmemaddr[1:0];
  assign req      = dmemREN | dmemWEN;
  assign ridx     = dmemaddr[2+WBITS +: IBITS];
  assign rtag     = dmemaddr[31 -: TBITS];
  assign rword    = (WBITS == 0) ? '0 : dmemaddr[2 +: WW];
  assign wb_last  = (wcnt_q == WW'(WPB - 1));
  assign fl_dirty = valid_q[fset_q][fway_q] && dirty_q[fset_q][fway_q];
  assign fl_last  = (fset_q == IBITS'(SETS - 1)) && (fway_q == AW'(WAYS - 1));

  // Tag lookup across the indexed set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[ridx][w] && (tag_q[ridx][w] == rtag)) begin
        hit     = 1'b1;
        hit_way = AW'(w);
      end
    end
  end

  // Victim: first invalid way, otherwise the first way holding the oldest age.
  always_comb begin
    logic          found;
    logic [AW-1:0] best;
    found = 1'b0;
    vic   = '0;
    best  = age_q[ridx][0];
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid_q[ridx][w]) begin
        found = 1'b1;
        vic   = AW'(w);
      end
    end
    if (!found) begin
      for (int w = 1; w < WAYS; w++) begin
        if (age_q[ridx][w] > best) begin
          best = age_q[ridx][w];
          vic  = AW'(w);
        end
      end
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and memory/datapath outputs.
  always_comb begin
    state_d  = state_q;
    dhit     = 1'b0;
    dmemload = '0;
    flushed  = 1'b0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = '0;
    dstore   = '0;
    case (state_q)
      S_IDLE: begin
        if (halt) begin
          state_d = S_FLUSH;
        end else if (req) begin
          if (hit) begin
            dhit     = 1'b1;
            dmemload = data_q[ridx][hit_way][rword];
          end else if (valid_q[ridx][vic] && dirty_q[ridx][vic]) begin
            state_d = S_WB;
          end else begin
            state_d = S_ALLOC;
          end
        end
      end
      S_WB: begin
        dWEN   = 1'b1;
        daddr  = mk_addr(tag_q[midx_q][vic_q], midx_q, wcnt_q);
        dstore = data_q[midx_q][vic_q][wcnt_q];
        if (!dwait && wb_last) state_d = halt ? S_FLUSH : S_ALLOC;
      end
      S_ALLOC: begin
        dREN  = 1'b1;
        daddr = mk_addr(mtag_q, midx_q, wcnt_q);
        if (!dwait && wb_last) state_d = halt ? S_FLUSH : S_IDLE;
      end
      S_FLUSH: begin
        if (fl_dirty) begin
          dWEN   = 1'b1;
          daddr  = mk_addr(tag_q[fset_q][fway_q], fset_q, wcnt_q);
          dstore = data_q[fset_q][fway_q][wcnt_q];
          if (!dwait && wb_last && fl_last) state_d = S_CNT;
        end else if (fl_last) begin
          state_d = S_CNT;
        end
      end
      S_CNT: begin
        dWEN   = 1'b1;
        daddr  = CNT_ADDR;
        dstore = hitcnt_q;
        if (!dwait) state_d = S_DONE;
      end
      S_DONE: flushed = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  // Control state: valid/dirty/age, miss bookkeeping, counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          age_q[s][w]   <= '0;
        end
      end
      hitcnt_q <= '0;
      missed_q <= 1'b0;
      vic_q    <= '0;
      mtag_q   <= '0;
      midx_q   <= '0;
      wcnt_q   <= '0;
      fset_q   <= '0;
      fway_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!halt && req) begin
            if (hit) begin
              if (dmemWEN) dirty_q[ridx][hit_way] <= 1'b1;
              // Hit way becomes youngest; ways not older than it age by one.
              for (int w = 0; w < WAYS; w++) begin
                if (AW'(w) == hit_way)
                  age_q[ridx][w] <= '0;
                else if ((age_q[ridx][w] <= age_q[ridx][hit_way]) &&
                         (age_q[ridx][w] != AW'(WAYS - 1)))
                  age_q[ridx][w] <= age_q[ridx][w] + 1'b1;
              end
              // The hit that completes a miss is not counted.
              if (missed_q)              missed_q <= 1'b0;
              else if (hitcnt_q != '1)   hitcnt_q <= hitcnt_q + 32'd1;
            end else begin
              missed_q <= 1'b1;
              vic_q    <= vic;
              mtag_q   <= rtag;
              midx_q   <= ridx;
              wcnt_q   <= '0;
            end
          end
        end
        S_WB: begin
          if (!dwait) begin
            if (wb_last) begin
              wcnt_q                  <= '0;
              dirty_q[midx_q][vic_q]  <= 1'b0;
            end else begin
              wcnt_q <= wcnt_q + 1'b1;
            end
          end
        end
        S_ALLOC: begin
          if (!dwait) begin
            if (wb_last) begin
              wcnt_q                 <= '0;
              valid_q[midx_q][vic_q] <= 1'b1;
              dirty_q[midx_q][vic_q] <= 1'b0;
            end else begin
              wcnt_q <= wcnt_q + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          if (fl_dirty && (dwait || !wb_last)) begin
            if (!dwait) wcnt_q <= wcnt_q + 1'b1;
          end else begin
            if (fl_dirty) begin
              dirty_q[fset_q][fway_q] <= 1'b0;
              wcnt_q                  <= '0;
            end
            // Index-major scan: step way, then set.
            if (fway_q == AW'(WAYS - 1)) begin
              fway_q <= '0;
              fset_q <= fset_q + 1'b1;
            end else begin
              fway_q <= fway_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Data and tag arrays; no reset needed since valid gates their use.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if ((state_q == S_IDLE) && !halt && req && hit && dmemWEN)
        data_q[ridx][hit_way][rword] <= dmemstore;
      if ((state_q == S_ALLOC) && !dwait) begin
        data_q[midx_q][vic_q][wcnt_q] <= dload;
        if (wb_last) tag_q[midx_q][vic_q] <= mtag_q;
      end
    end
  end

endmodule

// File: tb/tb_dcache_nway.sv
// Bench for dcache_nway: word-addressed memory model with programmable
// wait states, transfer log, and a read-data scoreboard.
module tb_dcache_nway;

  typedef struct packed {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
  } xfer_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        dmemREN, dmemWEN, halt;
  logic [31:0] dmemaddr, dmemstore;
  logic        dhit, flushed, dREN, dWEN, dwait;
  logic [31:0] dmemload, daddr, dstore, dload;

  logic [31:0] mem [0:4095];
  xfer_t       xlog [$];
  logic [31:0] exp_q [$];
  int          mw = 0;
  int          extra_wait = 0;
  int          checks = 0;
  int          errors = 0;
  logic        chk_en = 1'b0;

  dcache_nway dut (
    .CLK(CLK), .RST(RST),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .halt(halt), .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload)
  );

  always #5 CLK = ~CLK;

  // Memory model: each transfer is held for extra_wait busy cycles.
  assign dwait = (dREN || dWEN) && (mw < extra_wait);
  assign dload = mem[daddr[13:2]];

  always @(posedge CLK) begin
    if (!RST && (dREN || dWEN)) begin
      if (dwait) begin
        mw <= mw + 1;
      end else begin
        mw <= 0;
        if (dWEN) mem[daddr[13:2]] <= dstore;
        xlog.push_back('{we: dWEN, a: daddr, d: (dWEN ? dstore : dload)});
      end
    end else begin
      mw <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Invariants sampled every cycle once out of the first reset.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("excl_ren_wen", 32'(dREN & dWEN), 32'd0);
      if (halt) check("halt_no_dhit", 32'(dhit), 32'd0);
    end
  end

  // Issue one request and wait (bounded) for dhit; reads are scored.
  task automatic access(input string tag, input logic we, input logic [31:0] a,
                        input logic [31:0] d, output int lat);
    logic [31:0] e;
    dmemREN = !we; dmemWEN = we; dmemaddr = a; dmemstore = d;
    lat = 0;
    @(negedge CLK);
    while (!dhit && lat < 200) begin
      lat++;
      @(negedge CLK);
    end
    check({tag, "_dhit"}, 32'(dhit), 32'd1);
    if (!we && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_data"}, dmemload, e);
    end
    @(posedge CLK); #1;
    dmemREN = 1'b0; dmemWEN = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] e, input int elat);
    int lat;
    exp_q.push_back(e);
    access(tag, 1'b0, a, 32'h0, lat);
    check({tag, "_lat"}, 32'(lat), 32'(elat));
  endtask

  task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d, input int elat);
    int lat;
    access(tag, 1'b1, a, d, lat);
    check({tag, "_lat"}, 32'(lat), 32'(elat));
  endtask

  task automatic check_xfer(input string tag, input int i, input logic we,
                            input logic [31:0] a, input logic [31:0] d);
    xfer_t x;
    x = (i < xlog.size()) ? xlog[i] : '0;
    check({tag, "_we"}, 32'(x.we), 32'(we));
    check({tag, "_addr"}, x.a, a);
    check({tag, "_data"}, x.d, d);
  endtask

  task automatic reset_dut();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    xlog.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int l1, l2, nw;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[32'hE0 >> 2]  = 32'h11111111;  mem[32'hE4 >> 2]  = 32'h22222222;
    mem[32'hA0 >> 2]  = 32'h33333333;  mem[32'hA4 >> 2]  = 32'h44444444;
    mem[32'h1E0 >> 2] = 32'h66666666;  mem[32'h1E4 >> 2] = 32'h77777777;
    mem[32'h300 >> 2] = 32'h30003000;  mem[32'h400 >> 2] = 32'h40004000;
    mem[32'h500 >> 2] = 32'h50005000;
    RST = 1'b1; dmemREN = 1'b0; dmemWEN = 1'b0; halt = 1'b0;
    dmemaddr = '0; dmemstore = '0;

    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_dhit", 32'(dhit), 32'd0);
    check("rst_dren", 32'(dREN), 32'd0);
    check("rst_dwen", 32'(dWEN), 32'd0);
    check("rst_flushed", 32'(flushed), 32'd0);
    check("rst_daddr", daddr, 32'd0);
    check("rst_dstore", dstore, 32'd0);
    check("rst_dmemload", dmemload, 32'd0);
    @(posedge CLK); #1 RST = 1'b0;
    chk_en = 1'b1;
    xlog.delete();

    // Compulsory read miss, then a same-block hit
    rd("t1_miss", 32'hE0, 32'h11111111, 3);
    check("t1_nxfer", 32'(xlog.size()), 32'd2);
    check_xfer("t1_x0", 0, 1'b0, 32'hE0, 32'h11111111);
    check_xfer("t1_x1", 1, 1'b0, 32'hE4, 32'h22222222);
    rd("t1_hit", 32'hE4, 32'h22222222, 0);

    // Write hit, write miss into the other way, load back; no write-back yet
    xlog.delete();
    wr("t2_st_e0", 32'hE0, 32'hBEEFDEAD, 0);
    wr("t2_st_a4", 32'hA4, 32'hAAAABBBB, 3);
    rd("t2_ld_e0", 32'hE0, 32'hBEEFDEAD, 0);
    nw = 0;
    foreach (xlog[i]) if (xlog[i].we) nw++;
    check("t2_no_mem_writes", 32'(nw), 32'd0);
    check("t2_mem_e0", mem[32'hE0 >> 2], 32'h11111111);

    // Eviction of the dirty LRU block
    rd("t3_touch_a4", 32'hA4, 32'hAAAABBBB, 0);
    xlog.delete();
    wr("t3_st_1e0", 32'h1E0, 32'h55555555, 5);
    check("t3_nxfer", 32'(xlog.size()), 32'd4);
    check_xfer("t3_x0", 0, 1'b1, 32'hE0, 32'hBEEFDEAD);
    check_xfer("t3_x1", 1, 1'b1, 32'hE4, 32'h22222222);
    check_xfer("t3_x2", 2, 1'b0, 32'h1E0, 32'h66666666);
    check_xfer("t3_x3", 3, 1'b0, 32'h1E4, 32'h77777777);
    rd("t3_keep_a4", 32'hA4, 32'hAAAABBBB, 0);
    rd("t3_ld_1e0", 32'h1E0, 32'h55555555, 0);
    rd("t3_ld_1e4", 32'h1E4, 32'h77777777, 0);

    // Wait states on clean misses
    extra_wait = 3;
    exp_q.push_back(32'h30003000);
    access("t4_slow", 1'b0, 32'h300, 32'h0, l1);
    extra_wait = 0;
    exp_q.push_back(32'h40004000);
    access("t4_fast", 1'b0, 32'h400, 32'h0, l2);
    check("t4_slow_lat", 32'(l1), 32'd9);
    check("t4_lat_delta", 32'(l1 - l2), 32'd6);

    // Reset in the middle of a fill
    dmemREN = 1'b1; dmemaddr = 32'h500;
    @(posedge CLK); #1;
    check("t5_in_alloc_dren", 32'(dREN), 32'd1);
    RST = 1'b1;
    @(posedge CLK); #1;
    check("t5_rst_dren", 32'(dREN), 32'd0);
    check("t5_rst_dhit", 32'(dhit), 32'd0);
    dmemREN = 1'b0;
    RST = 1'b0;
    rd("t5_remiss", 32'h500, 32'h50005000, 3);

    // Flush with both ways of set 4 dirty and three counted hits
    reset_dut();
    wr("t6_st_e0", 32'hE0, 32'hD0D0D0D0, 3);
    wr("t6_st_a0", 32'hA0, 32'hD1D1D1D1, 3);
    wr("t6_st_e4", 32'hE4, 32'hD2D2D2D2, 0);
    wr("t6_st_a4", 32'hA4, 32'hD3D3D3D3, 0);
    rd("t6_ld_e0", 32'hE0, 32'hD0D0D0D0, 0);
    xlog.delete();
    halt = 1'b1;
    l1 = 0;
    @(negedge CLK);
    while (!flushed && l1 < 100) begin
      l1++;
      @(negedge CLK);
    end
    check("t6_flushed", 32'(flushed), 32'd1);
    check("t6_nxfer", 32'(xlog.size()), 32'd5);
    check_xfer("t6_x0", 0, 1'b1, 32'hE0, 32'hD0D0D0D0);
    check_xfer("t6_x1", 1, 1'b1, 32'hE4, 32'hD2D2D2D2);
    check_xfer("t6_x2", 2, 1'b1, 32'hA0, 32'hD1D1D1D1);
    check_xfer("t6_x3", 3, 1'b1, 32'hA4, 32'hD3D3D3D3);
    check_xfer("t6_cnt", 4, 1'b1, 32'h3100, 32'd3);
    check("t6_mem_cnt", mem[32'h3100 >> 2], 32'd3);
    dmemREN = 1'b1; dmemaddr = 32'hE0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("t6_done_dhit", 32'(dhit), 32'd0);
      check("t6_done_mem", 32'(dREN | dWEN), 32'd0);
      check("t6_done_flushed", 32'(flushed), 32'd1);
    end
    dmemREN = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
